// File: rtl/tag_store.sv
// Tag store for the direct-mapped cache: per-line tag, valid and dirty bits,
// registered tag compare, dirty report, running valid-line count, and a
// hardware sweep that invalidates every line after reset or on flush.
module tag_store #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lookup_en,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic               resp_dirty,
  output logic [TAG_W-1:0]   resp_tag,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic               flush_req,
  output logic               busy,
  output logic               flush_done,
  output logic [INDEX_W:0]   valid_count
);

  localparam int DEPTH = 2 ** INDEX_W;
  localparam logic [INDEX_W-1:0] LAST_INDEX = '1;
  localparam logic [INDEX_W:0]   FULL_COUNT = (INDEX_W + 1)'(DEPTH);

  typedef enum logic {
    SWEEP,
    IDLE
  } state_t;

  state_t state;
  state_t state_next;

  logic [INDEX_W-1:0] cnt;

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [DEPTH-1:0] valid_mem;
  logic [DEPTH-1:0] dirty_mem;

  logic             lookup_ok;
  logic             write_ok;
  logic             flush_ok;
  logic             rd_valid;
  logic             rd_dirty;
  logic [TAG_W-1:0] rd_tag;
  logic             old_valid;

  assign lookup_ok = (state == IDLE) && lookup_en;
  assign write_ok  = (state == IDLE) && wr_en;
  assign flush_ok  = (state == IDLE) && flush_req;

  assign rd_valid  = valid_mem[lookup_index];
  assign rd_dirty  = dirty_mem[lookup_index];
  assign rd_tag    = tag_mem[lookup_index];
  assign old_valid = valid_mem[wr_index];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SWEEP;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: sweep ends on the last index, flush only honoured when idle
  always_comb begin
    state_next = state;
    case (state)
      SWEEP: if (cnt == LAST_INDEX) state_next = IDLE;
      IDLE:  if (flush_req)         state_next = SWEEP;
      default: state_next = SWEEP;
    endcase
  end

  // FSM outputs: busy for the whole sweep, flush_done while the last entry is written
  always_comb begin
    busy       = (state == SWEEP);
    flush_done = (state == SWEEP) && (cnt == LAST_INDEX);
  end

  // Sweep counter; parked at zero outside a sweep so the next sweep starts at index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == SWEEP) begin
      cnt <= (cnt == LAST_INDEX) ? '0 : cnt + 1'b1;
    end else if (flush_ok) begin
      cnt <= '0;
    end
  end

  // Storage: sweep clears one entry per cycle, otherwise accepted writes update an entry
  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      tag_mem[cnt]   <= '0;
      valid_mem[cnt] <= 1'b0;
      dirty_mem[cnt] <= 1'b0;
    end else if (write_ok) begin
      tag_mem[wr_index]   <= wr_tag;
      valid_mem[wr_index] <= wr_valid;
      dirty_mem[wr_index] <= wr_dirty;
    end
  end

  // Registered lookup response; reads pre-write contents on a same-index write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_dirty <= 1'b0;
      resp_tag   <= '0;
    end else if (lookup_ok) begin
      resp_valid <= 1'b1;
      resp_hit   <= rd_valid && (rd_tag == lookup_tag);
      resp_dirty <= rd_valid && rd_dirty;
      resp_tag   <= rd_tag;
    end else begin
      resp_valid <= 1'b0;
    end
  end

  // Valid-line count: tracks valid-bit transitions on accepted writes, zeroed on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_count <= '0;
    end else if (flush_ok) begin
      valid_count <= '0;
    end else if (write_ok) begin
      if (!old_valid && wr_valid && (valid_count != FULL_COUNT)) begin
        valid_count <= valid_count + 1'b1;
      end else if (old_valid && !wr_valid && (valid_count != '0)) begin
        valid_count <= valid_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tag_store.sv
// Directed bench for tag_store: vector table for lookup/write/count behaviour,
// plus hand-written sequences for sweep length, flush and mid-sweep reset.
module tb_tag_store;

  localparam int INDEX_W = 10;
  localparam int TAG_W   = 21;
  localparam int DEPTH   = 2 ** INDEX_W;

  logic               clk;
  logic               rst_n;
  logic               lookup_en;
  logic [INDEX_W-1:0] lookup_index;
  logic [TAG_W-1:0]   lookup_tag;
  logic               resp_valid;
  logic               resp_hit;
  logic               resp_dirty;
  logic [TAG_W-1:0]   resp_tag;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [TAG_W-1:0]   wr_tag;
  logic               wr_valid;
  logic               wr_dirty;
  logic               flush_req;
  logic               busy;
  logic               flush_done;
  logic [INDEX_W:0]   valid_count;

  int errors = 0;
  int checks = 0;

  tag_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_en    (lookup_en),
    .lookup_index (lookup_index),
    .lookup_tag   (lookup_tag),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_dirty   (resp_dirty),
    .resp_tag     (resp_tag),
    .wr_en        (wr_en),
    .wr_index     (wr_index),
    .wr_tag       (wr_tag),
    .wr_valid     (wr_valid),
    .wr_dirty     (wr_dirty),
    .flush_req    (flush_req),
    .busy         (busy),
    .flush_done   (flush_done),
    .valid_count  (valid_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic               l_en;
    logic [INDEX_W-1:0] l_idx;
    logic [TAG_W-1:0]   l_tag;
    logic               w_en;
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_v;
    logic               w_d;
    logic               e_rv;
    logic               e_hit;
    logic               e_dirty;
    logic [TAG_W-1:0]   e_tag;
    logic [INDEX_W:0]   e_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    lookup_en    = 1'b0;
    lookup_index = '0;
    lookup_tag   = '0;
    wr_en        = 1'b0;
    wr_index     = '0;
    wr_tag       = '0;
    wr_valid     = 1'b0;
    wr_dirty     = 1'b0;
    flush_req    = 1'b0;
  endtask

  // Drive one cycle of requests, step past the edge, leave outputs ready to sample
  task automatic apply(input logic l_en, input logic [INDEX_W-1:0] l_idx, input logic [TAG_W-1:0] l_tag,
                       input logic w_en, input logic [INDEX_W-1:0] w_idx, input logic [TAG_W-1:0] w_tag,
                       input logic w_v, input logic w_d, input logic flush);
    lookup_en    = l_en;
    lookup_index = l_idx;
    lookup_tag   = l_tag;
    wr_en        = w_en;
    wr_index     = w_idx;
    wr_tag       = w_tag;
    wr_valid     = w_v;
    wr_dirty     = w_d;
    flush_req    = flush;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Follow a sweep from its first cycle; at sample inject_at, fire flush/lookup/write
  // (to idx 9 with inj_tag) for one cycle, all of which must be ignored.
  task automatic watch_sweep(input string tag_name, input int inject_at, input logic [TAG_W-1:0] inj_tag);
    int busy_cycles  = 0;
    int pulses       = 0;
    int pulse_at     = -1;
    int resp_pulses  = 0;
    for (int i = 0; i < DEPTH + 100; i++) begin
      if (i > 0 && resp_valid) resp_pulses++;
      if (flush_done) begin
        pulses++;
        pulse_at = i;
      end
      if (!busy) break;
      busy_cycles++;
      if (i == inject_at) begin
        flush_req    = 1'b1;
        lookup_en    = 1'b1;
        lookup_index = 10'd9;
        lookup_tag   = inj_tag;
        wr_en        = 1'b1;
        wr_index     = 10'd9;
        wr_tag       = inj_tag;
        wr_valid     = 1'b1;
        wr_dirty     = 1'b1;
      end else begin
        clear_inputs();
      end
      @(posedge clk);
      #1;
    end
    clear_inputs();
    check({tag_name, "_busy_cycles"}, busy_cycles, DEPTH);
    check({tag_name, "_done_pulses"}, pulses, 1);
    check({tag_name, "_done_on_last"}, pulse_at, DEPTH - 1);
    check({tag_name, "_no_resp"}, resp_pulses, 0);
    check({tag_name, "_idle_after"}, {31'd0, busy}, 0);
    check({tag_name, "_count_after"}, {21'd0, valid_count}, 0);
  endtask

  initial begin
    vecs[0]  = '{"lk5_after_sweep",   1, 10'd5,     21'h0,      0, 10'd0,     21'h0,      0, 0, 1, 0, 0, 21'h0,      11'd0};
    vecs[1]  = '{"wr_3ff",            0, 10'd0,     21'h0,      1, 10'h3FF,   21'h1ABCDE, 1, 0, 0, 0, 0, 21'h0,      11'd1};
    vecs[2]  = '{"lk_3ff_hit",        1, 10'h3FF,   21'h1ABCDE, 0, 10'd0,     21'h0,      0, 0, 1, 1, 0, 21'h1ABCDE, 11'd1};
    vecs[3]  = '{"lk_3ff_tag_lsb",    1, 10'h3FF,   21'h1ABCDF, 0, 10'd0,     21'h0,      0, 0, 1, 0, 0, 21'h1ABCDE, 11'd1};
    vecs[4]  = '{"rbw_idx7",          1, 10'd7,     21'h42,     1, 10'd7,     21'h42,     1, 1, 1, 0, 0, 21'h0,      11'd2};
    vecs[5]  = '{"lk7_hit_dirty",     1, 10'd7,     21'h42,     0, 10'd0,     21'h0,      0, 0, 1, 1, 1, 21'h42,     11'd2};
    vecs[6]  = '{"fill1_hold",        0, 10'd0,     21'h0,      1, 10'd1,     21'h11,     1, 0, 0, 1, 1, 21'h42,     11'd3};
    vecs[7]  = '{"fill2",             0, 10'd0,     21'h0,      1, 10'd2,     21'h22,     1, 0, 0, 1, 1, 21'h42,     11'd4};
    vecs[8]  = '{"fill3",             0, 10'd0,     21'h0,      1, 10'd3,     21'h33,     1, 0, 0, 1, 1, 21'h42,     11'd5};
    vecs[9]  = '{"inval2",            0, 10'd0,     21'h0,      1, 10'd2,     21'h22,     0, 0, 0, 1, 1, 21'h42,     11'd4};
    vecs[10] = '{"rewrite1_valid",    0, 10'd0,     21'h0,      1, 10'd1,     21'h55,     1, 0, 0, 1, 1, 21'h42,     11'd4};
    vecs[11] = '{"lk1_new_tag",       1, 10'd1,     21'h55,     0, 10'd0,     21'h0,      0, 0, 1, 1, 0, 21'h55,     11'd4};
    vecs[12] = '{"lk2_invalid",       1, 10'd2,     21'h22,     0, 10'd0,     21'h0,      0, 0, 1, 0, 0, 21'h22,     11'd4};
    vecs[13] = '{"wr2_dirty_invalid", 0, 10'd0,     21'h0,      1, 10'd2,     21'h22,     0, 1, 0, 0, 0, 21'h22,     11'd4};
    vecs[14] = '{"lk2_dirty_masked",  1, 10'd2,     21'h22,     0, 10'd0,     21'h0,      0, 0, 1, 0, 0, 21'h22,     11'd4};
    vecs[15] = '{"inval3",            0, 10'd0,     21'h0,      1, 10'd3,     21'h33,     0, 0, 0, 0, 0, 21'h22,     11'd3};

    clear_inputs();
    rst_n = 1'b0;
    #2;
    check("reset_busy",        {31'd0, busy}, 1);
    check("reset_resp_valid",  {31'd0, resp_valid}, 0);
    check("reset_resp_hit",    {31'd0, resp_hit}, 0);
    check("reset_resp_dirty",  {31'd0, resp_dirty}, 0);
    check("reset_resp_tag",    {11'd0, resp_tag}, 0);
    check("reset_flush_done",  {31'd0, flush_done}, 0);
    check("reset_valid_count", {21'd0, valid_count}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    watch_sweep("init", DEPTH + 500, 21'h0);

    for (int v = 0; v < 16; v++) begin
      apply(vecs[v].l_en, vecs[v].l_idx, vecs[v].l_tag,
            vecs[v].w_en, vecs[v].w_idx, vecs[v].w_tag, vecs[v].w_v, vecs[v].w_d, 1'b0);
      check({vecs[v].name, "_rv"},    {31'd0, resp_valid}, {31'd0, vecs[v].e_rv});
      check({vecs[v].name, "_hit"},   {31'd0, resp_hit},   {31'd0, vecs[v].e_hit});
      check({vecs[v].name, "_dirty"}, {31'd0, resp_dirty}, {31'd0, vecs[v].e_dirty});
      check({vecs[v].name, "_tag"},   {11'd0, resp_tag},   {11'd0, vecs[v].e_tag});
      check({vecs[v].name, "_count"}, {21'd0, valid_count}, {21'd0, vecs[v].e_cnt});
    end

    // Flush together with a lookup and a write: both complete, then the sweep erases
    apply(1'b1, 10'd1, 21'h55, 1'b1, 10'd9, 21'h99, 1'b1, 1'b0, 1'b1);
    check("flush_lk_rv",    {31'd0, resp_valid}, 1);
    check("flush_lk_hit",   {31'd0, resp_hit}, 1);
    check("flush_lk_tag",   {11'd0, resp_tag}, 32'h55);
    check("flush_busy",     {31'd0, busy}, 1);
    check("flush_count",    {21'd0, valid_count}, 0);
    watch_sweep("flush", 300, 21'h99);
    apply(1'b1, 10'd9, 21'h99, 1'b0, 10'd0, 21'h0, 1'b0, 1'b0, 1'b0);
    check("post_flush_lk9_rv",  {31'd0, resp_valid}, 1);
    check("post_flush_lk9_hit", {31'd0, resp_hit}, 0);
    apply(1'b1, 10'd1, 21'h55, 1'b0, 10'd0, 21'h0, 1'b0, 1'b0, 1'b0);
    check("post_flush_lk1_hit", {31'd0, resp_hit}, 0);

    // Reset in the middle of a sweep restarts it from index 0
    apply(1'b0, 10'd0, 21'h0, 1'b1, 10'd9, 21'h77, 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", {21'd0, valid_count}, 1);
    apply(1'b0, 10'd0, 21'h0, 1'b0, 10'd0, 21'h0, 1'b0, 1'b0, 1'b1);
    repeat (500) @(posedge clk);
    #1;
    check("mid_sweep_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {31'd0, busy}, 1);
    check("mid_rst_done",  {31'd0, flush_done}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    watch_sweep("rst_mid", 100, 21'h77);
    apply(1'b1, 10'd9, 21'h77, 1'b0, 10'd0, 21'h0, 1'b0, 1'b0, 1'b0);
    check("post_rst_lk9_rv",  {31'd0, resp_valid}, 1);
    check("post_rst_lk9_hit", {31'd0, resp_hit}, 0);
    check("post_rst_count",   {21'd0, valid_count}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
